wb_arbiter: RTL and testbench

Register-file write-port owner for the cached OTTER pipeline. Merges the in-order writeback stream (ALU/JAL/CSR results) with out-of-order load returns from the data cache, which arrive late on a miss. It buffers load returns in a small FIFO and performs load byte/half alignment and sign extension. A pending-load scoreboard feeds the hazard unit. Sole driver of the register file's EN/WA/WD inputs.

---
 rtl/otter_wb_pkg.sv | 49 ++++
 rtl/ld_ret_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_wb_pkg.sv
// otter_wb_pkg
// Shared types and helpers for the register-file write-port arbiter:
//   ld_size_t   - load access width
//   ld_ret_t    - one buffered load return (destination, raw word, width,
//                 zero-extend flag, byte offset)
//   to_ld_size  - maps the raw 2-bit size field onto ld_size_t (11 -> word)
//   ld_align    - extracts and extends the addressed byte/half/word
package otter_wb_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        ld_size_t    size;
        logic        is_unsigned;
        logic [1:0]  offset;
    } ld_ret_t;

    function automatic ld_size_t to_ld_size(input logic [1:0] raw);
        ld_size_t s;
        case (raw)
            2'b00:   s = LD_B;
            2'b01:   s = LD_H;
            default: s = LD_W;   // 11 is treated as a word access
        endcase
        return s;
    endfunction

    function automatic logic [31:0] ld_align(input ld_ret_t r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = r.data[{r.offset, 3'b000} +: 8];
        // Half accesses are naturally aligned, so only offset[1] matters.
        h = r.offset[1] ? r.data[31:16] : r.data[15:0];
        case (r.size)
            LD_B:    res = {{24{b[7] & ~r.is_unsigned}}, b};
            LD_H:    res = {{16{h[15] & ~r.is_unsigned}}, h};
            default: res = r.data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ld_ret_fifo.sv
// ld_ret_fifo
// Small circular buffer for load returns arriving from the data cache.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (drops all entries)
//   push, din       enqueue one entry (ignored when full)
//   pop             dequeue the head entry (ignored when empty)
//   head            current oldest entry, combinational from storage
//   count           number of valid entries (0..DEPTH)
//   full, empty     occupancy flags
module ld_ret_fifo
    import otter_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  ld_ret_t                      din,
    input  logic                         pop,
    output ld_ret_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    ld_ret_t         mem_reg [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    // Payload storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Sole owner of the register-file write port. Merges the in-order
// writeback stream with buffered, possibly late, load returns; aligns and
// extends loaded data; keeps a per-register pending-load bitmap.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wb_valid/wb_rd/wb_data     in-order writeback candidate
//   wb_stall                   writeback lost this cycle (combinational)
//   ld_issue_valid/_rd         load issued to cache (sets busy bit)
//   lr_valid/lr_ready          load-return handshake
//   lr_rd/lr_data/lr_size/lr_unsigned/lr_offset   load-return payload
//   busy                       outstanding-load bitmap, bit 0 always 0
//   rf_en/rf_wa/rf_wd          registered register-file write port
module wb_arbiter
    import otter_wb_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_rd,
    input  logic [31:0] lr_data,
    input  logic [1:0]  lr_size,
    input  logic        lr_unsigned,
    input  logic [1:0]  lr_offset,
    output logic [31:0] busy,
    output logic        rf_en,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    ld_ret_t         lr_entry;
    ld_ret_t         head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            w_present;
    logic            l_present;
    logic            load_wins;
    logic            lr_push;

    logic [AW-1:0]   age_reg;
    logic [AW-1:0]   age_next;
    logic [31:0]     busy_reg;
    logic [31:0]     busy_next;

    logic            rf_en_reg,  rf_en_next;
    logic [4:0]      rf_wa_reg,  rf_wa_next;
    logic [31:0]     rf_wd_reg,  rf_wd_next;

    always_comb begin
        lr_entry             = '0;
        lr_entry.rd          = lr_rd;
        lr_entry.data        = lr_data;
        lr_entry.size        = to_ld_size(lr_size);
        lr_entry.is_unsigned = lr_unsigned;
        lr_entry.offset      = lr_offset;
    end

    // No pass-through: a full FIFO refuses even if it pops this cycle.
    assign lr_ready = (fifo_count < CW'(DEPTH));
    assign lr_push  = lr_valid && lr_ready;

    ld_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lr_push),
        .din   (lr_entry),
        .pop   (load_wins),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Writebacks to x0 are consumed silently and never compete for the port.
    assign w_present = wb_valid && (wb_rd != 5'd0);
    assign l_present = !fifo_empty;
    // The load head yields to writeback only while it has room to wait.
    assign load_wins = l_present && (fifo_full || (age_reg >= AGE_MAX) || !w_present);
    assign wb_stall  = w_present && load_wins;

    always_comb begin
        age_next = age_reg;
        if (!l_present || load_wins) begin
            age_next = '0;
        end else if (age_reg < AGE_MAX) begin
            age_next = age_reg + AW'(1);
        end
    end

    // A pop and a new issue to the same register can coincide; the new
    // issue must stay visible, so set takes precedence over clear.
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
        assign busy_next[gi] = (ld_issue_valid && (ld_issue_rd == 5'(gi)))
                             | (busy_reg[gi] & ~(load_wins && (head.rd == 5'(gi))));
    end

    always_comb begin
        rf_en_next = 1'b0;
        rf_wa_next = rf_wa_reg;
        rf_wd_next = rf_wd_reg;
        if (load_wins) begin
            // A load to x0 still consumes its slot but writes nothing.
            rf_en_next = (head.rd != 5'd0);
            rf_wa_next = head.rd;
            rf_wd_next = ld_align(head);
        end else if (w_present) begin
            rf_en_next = 1'b1;
            rf_wa_next = wb_rd;
            rf_wd_next = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_reg   <= '0;
            busy_reg  <= '0;
            rf_en_reg <= 1'b0;
            rf_wa_reg <= '0;
            rf_wd_reg <= '0;
        end else begin
            age_reg   <= age_next;
            busy_reg  <= busy_next;
            rf_en_reg <= rf_en_next;
            rf_wa_reg <= rf_wa_next;
            rf_wd_reg <= rf_wd_next;
        end
    end

    assign busy  = busy_reg;
    assign rf_en = rf_en_reg;
    assign rf_wa = rf_wa_reg;
    assign rf_wd = rf_wd_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DEPTH     = 2;
    localparam int AGE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_rd;
    logic [31:0] lr_data;
    logic [1:0]  lr_size;
    logic        lr_unsigned;
    logic [1:0]  lr_offset;
    logic [31:0] busy;
    logic        rf_en;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_stall       (wb_stall),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .lr_valid       (lr_valid),
        .lr_ready       (lr_ready),
        .lr_rd          (lr_rd),
        .lr_data        (lr_data),
        .lr_size        (lr_size),
        .lr_unsigned    (lr_unsigned),
        .lr_offset      (lr_offset),
        .busy           (busy),
        .rf_en          (rf_en),
        .rf_wa          (rf_wa),
        .rf_wd          (rf_wd)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
    } ret_t;

    typedef struct {
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    // Reference model state
    ret_t        fifo_m[$];
    int          age_m;
    logic [31:0] busy_m;
    exp_t        sb[$];

    int          errors = 0;
    int          checks = 0;

    logic        obs_stall;
    logic        obs_ready;
    logic        last_acc;
    logic [4:0]  last_wa;
    logic [31:0] last_wd;
    exp_t        mon_e;
    int          pend[$];

    logic [1:0]  al_size [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        al_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  al_off  [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] al_exp  [4] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h80FF7F01};

    function automatic logic [31:0] model_align(input ret_t r);
        logic [31:0] v;
        if (r.size == 2'd0) begin
            v = (r.data >> (8 * r.off)) & 32'h0000_00FF;
            if (!r.uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (r.size == 2'd1) begin
            v = (r.data >> (16 * (r.off / 2))) & 32'h0000_FFFF;
            if (!r.uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = r.data;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        wb_valid       = 1'b0;
        wb_rd          = 5'd0;
        wb_data        = 32'd0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = 5'd0;
        lr_valid       = 1'b0;
        lr_rd          = 5'd0;
        lr_data        = 32'd0;
        lr_size        = 2'd0;
        lr_unsigned    = 1'b0;
        lr_offset      = 2'd0;
    endtask

    // One clock cycle: inputs already driven at the negedge. Predicts the
    // write, checks combinational outputs, advances the model at the edge.
    task automatic step();
        logic  w, l, lw, acc, illegal;
        ret_t  h, r;
        exp_t  e;
        #1;
        obs_stall = wb_stall;
        obs_ready = lr_ready;
        e = '{1'b0, 5'd0, 32'd0};
        if (!rst_n) begin
            last_acc = 1'b0;
            sb.push_back(e);
            @(posedge clk);
            fifo_m.delete();
            age_m  = 0;
            busy_m = '0;
        end else begin
            w  = wb_valid && (wb_rd != 5'd0);
            l  = fifo_m.size() > 0;
            lw = l && (fifo_m.size() == DEPTH || age_m >= AGE_LIMIT || !w);
            chk("wb_stall", 32'(wb_stall), 32'(w && lw));
            chk("lr_ready", 32'(lr_ready), 32'(fifo_m.size() < DEPTH));
            if (l) h = fifo_m[0];
            if (lw) begin
                e.en = (h.rd != 5'd0);
                e.wa = h.rd;
                e.wd = model_align(h);
            end else if (w) begin
                e.en = 1'b1;
                e.wa = wb_rd;
                e.wd = wb_data;
            end
            sb.push_back(e);
            illegal = ld_issue_valid && (ld_issue_rd != 5'd0) && busy_m[ld_issue_rd]
                      && !(lw && (h.rd == ld_issue_rd));
            chk("issue_legal", 32'(illegal), 32'd0);
            acc = lr_valid && (fifo_m.size() < DEPTH);
            last_acc = acc;
            r.rd = lr_rd; r.data = lr_data; r.size = lr_size; r.uns = lr_unsigned; r.off = lr_offset;
            @(posedge clk);
            if (lw) begin
                if (h.rd != 5'd0) busy_m[h.rd] = 1'b0;
                void'(fifo_m.pop_front());
                age_m = 0;
            end else if (l) begin
                if (age_m < AGE_LIMIT) age_m++;
            end else begin
                age_m = 0;
            end
            if (acc) fifo_m.push_back(r);
            if (ld_issue_valid && ld_issue_rd != 5'd0) busy_m[ld_issue_rd] = 1'b1;
        end
        #2;
        chk("busy", busy, busy_m);
        @(negedge clk);
    endtask

    // Monitor: one expected entry per cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("rf_en", 32'(rf_en), 32'(mon_e.en));
            if (mon_e.en) begin
                chk("rf_wa", 32'(rf_wa), 32'(mon_e.wa));
                chk("rf_wd", rf_wd, mon_e.wd);
            end
        end
        if (rf_en === 1'b1) begin
            last_wa = rf_wa;
            last_wd = rf_wd;
            $display("write rf[%0d] <= 0x%08h at %0t", rf_wa, rf_wd, $time);
        end
    end

    initial begin
        int stall_cnt, stall_at, ret_idx, cand;
        logic hold_wb;

        set_idle();
        rst_n  = 1'b0;
        age_m  = 0;
        busy_m = '0;
        @(negedge clk);

        // Reset held with activity on every input
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234_5678;
        lr_valid = 1'b1; lr_rd = 5'd2; lr_data = 32'hAAAA_5555;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd8;
        repeat (3) step();
        chk("rst_rf_en", 32'(rf_en), 32'd0);
        chk("rst_rf_wa", 32'(rf_wa), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_busy", busy, 32'd0);
        rst_n = 1'b1;
        set_idle();
        step();
        chk("ready_after_rst", 32'(obs_ready), 32'd1);
        repeat (2) step();

        // Writeback only
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        chk("wb_only_stall", 32'(obs_stall), 32'd0);
        set_idle();
        step();
        chk("wb_only_wa", 32'(last_wa), 32'd5);
        chk("wb_only_wd", last_wd, 32'hDEAD_BEEF);

        // Load alignment, one return at a time with WB idle
        for (int i = 0; i < 4; i++) begin
            ld_issue_valid = 1'b1; ld_issue_rd = 5'(11 + i);
            step();
            set_idle();
            lr_valid = 1'b1; lr_rd = 5'(11 + i); lr_data = 32'h80FF_7F01;
            lr_size = al_size[i]; lr_unsigned = al_uns[i]; lr_offset = al_off[i];
            step();
            set_idle();
            step();
            chk($sformatf("align_%0d", i), last_wd, al_exp[i]);
        end

        // Busy set and clear for rd 7
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        step();
        set_idle();
        chk("busy7_set", 32'(busy[7]), 32'd1);
        lr_valid = 1'b1; lr_rd = 5'd7; lr_data = 32'h0000_0777; lr_size = 2'd2;
        step();
        set_idle();
        chk("busy7_held", 32'(busy[7]), 32'd1);
        step();
        chk("busy7_clr", 32'(busy[7]), 32'd0);
        chk("busy7_wa", 32'(last_wa), 32'd7);

        // Re-issue to rd 9 in the same cycle its older load pops
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        step();
        set_idle();
        lr_valid = 1'b1; lr_rd = 5'd9; lr_data = 32'h0000_0999; lr_size = 2'd2;
        step();
        set_idle();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        step();
        set_idle();
        chk("busy9_kept", 32'(busy[9]), 32'd1);
        lr_valid = 1'b1; lr_rd = 5'd9; lr_data = 32'h0000_0998; lr_size = 2'd2;
        step();
        set_idle();
        step();
        chk("busy9_clr", 32'(busy[9]), 32'd0);

        // Starvation guard: continuous writeback plus one load return
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
        step();
        set_idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3000_0000;
        lr_valid = 1'b1; lr_rd = 5'd10; lr_data = 32'h1010_1010; lr_size = 2'd2;
        step();
        lr_valid = 1'b0;
        wb_data = wb_data + 32'd1;
        stall_cnt = 0;
        stall_at  = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (obs_stall) begin
                stall_cnt++;
                stall_at = i;
            end else begin
                wb_data = wb_data + 32'd1;
            end
        end
        chk("starve_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("starve_bound", 32'(stall_at >= 1 && stall_at <= AGE_LIMIT + 1), 32'd1);
        chk("starve_busy10", 32'(busy[10]), 32'd0);
        set_idle();
        repeat (2) step();

        // Full FIFO: two x0 returns while writeback is busy
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444_0000;
        lr_valid = 1'b1; lr_rd = 5'd0; lr_data = 32'h0BAD_0BAD; lr_size = 2'd2;
        step();
        step();
        lr_valid = 1'b0;
        step();
        chk("full_ready", 32'(obs_ready), 32'd0);
        chk("full_stall", 32'(obs_stall), 32'd1);
        step();
        chk("full_ready_back", 32'(obs_ready), 32'd1);
        set_idle();
        repeat (4) step();

        // Randomized traffic against the model, with one mid-run reset
        hold_wb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold_wb) begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_data  = $urandom;
            end
            lr_valid = 1'b0;
            ret_idx  = -1;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                ret_idx     = $urandom_range(0, pend.size() - 1);
                lr_valid    = 1'b1;
                lr_rd       = 5'(pend[ret_idx]);
                lr_data     = $urandom;
                lr_size     = 2'($urandom_range(0, 3));
                lr_unsigned = 1'($urandom_range(0, 1));
                lr_offset   = 2'($urandom_range(0, 3));
            end
            ld_issue_valid = 1'b0;
            if (pend.size() < 6 && $urandom_range(0, 1) == 0) begin
                cand = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
                if (cand == 0 || !busy_m[cand]) begin
                    ld_issue_valid = 1'b1;
                    ld_issue_rd    = 5'(cand);
                end
            end
            rst_n = !(n == 200 || n == 201);
            step();
            if (!rst_n) begin
                pend.delete();
                hold_wb = 1'b0;
            end else begin
                if (lr_valid && last_acc) pend.delete(ret_idx);
                if (ld_issue_valid) pend.push_back(int'(ld_issue_rd));
                hold_wb = obs_stall;
            end
        end
        rst_n = 1'b1;
        set_idle();
        repeat (8) step();
        chk("drain_ready", 32'(lr_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
